// File: rtl/ir_pkg.sv
// Shared key codes, FSM state encoding and the key-table helpers for the IR
// remote command decoder.
package ir_pkg;

  localparam logic [7:0] KEY_1       = 8'h01;
  localparam logic [7:0] KEY_2       = 8'h02;
  localparam logic [7:0] KEY_3       = 8'h03;
  localparam logic [7:0] KEY_4       = 8'h04;
  localparam logic [7:0] KEY_5       = 8'h05;
  localparam logic [7:0] KEY_6       = 8'h06;
  localparam logic [7:0] KEY_7       = 8'h07;
  localparam logic [7:0] KEY_8       = 8'h08;
  localparam logic [7:0] KEY_ALL_ON  = 8'h1A;
  localparam logic [7:0] KEY_ALL_OFF = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic key_in_table(input logic [7:0] key);
    return ((key >= KEY_1) && (key <= KEY_8)) ||
           (key == KEY_ALL_ON) || (key == KEY_ALL_OFF);
  endfunction

  // KEY_n toggles light n; key[2:0]-1 wraps 8 -> 7, so the low bits suffice.
  function automatic logic [7:0] apply_key(input logic [7:0] light,
                                           input logic [7:0] key);
    logic [7:0] res;
    logic [2:0] idx;
    res = light;
    idx = key[2:0] - 3'd1;
    if (key == KEY_ALL_ON) begin
      res = 8'hFF;
    end else if (key == KEY_ALL_OFF) begin
      res = 8'h00;
    end else if ((key >= KEY_1) && (key <= KEY_8)) begin
      res[idx] = ~light[idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/ir_frame_check.sv
// Combinational NEC frame validation: address match, key/inverted-key
// checksum, and key present in the command table.
module ir_frame_check
  import ir_pkg::*;
#(
  parameter logic [15:0] ADDR = 16'h6B86
) (
  input  logic [31:0] frame_i,
  output logic        valid_o
);

  logic addr_ok;
  logic sum_ok;
  logic key_ok;

  assign addr_ok = (frame_i[15:0] == ADDR);
  assign sum_ok  = (frame_i[23:16] == ~frame_i[31:24]);
  assign key_ok  = key_in_table(frame_i[23:16]);
  assign valid_o = addr_ok && sum_ok && key_ok;

endmodule

// File: rtl/ir_cmd_decoder.sv
// IR remote command decoder: validates received NEC frames, drives eight
// light toggles, and suppresses auto-repeat of the same key for HOLDOFF cycles.
module ir_cmd_decoder
  import ir_pkg::*;
#(
  parameter logic [15:0] ADDR    = 16'h6B86,
  parameter int unsigned HOLDOFF = 12_500_000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iDATA_READY,
  input  logic [31:0] iDATA,
  output logic [7:0]  oLIGHT,
  output logic [7:0]  oKEY,
  output logic        oKEY_VALID,
  output logic        oERR,
  output logic [7:0]  oERR_CNT,
  output state_e      oSTATE
);

  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

  // Handshake: iDATA_READY is a level flag with no ready back-pressure; a
  // frame is taken only on its 0->1 transition while in IDLE or HOLD.
  state_e          state_q, state_d;
  logic            rdy_q;
  logic [31:0]     data_q, data_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            from_hold_q, from_hold_d;
  logic            err_pend_q, err_pend_d;
  logic [7:0]      light_q, light_d;
  logic [7:0]      key_q, key_d;
  logic            kv_q, kv_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            rise;
  logic            frame_valid;

  ir_frame_check #(.ADDR(ADDR)) u_frame_check (
    .frame_i (data_q),
    .valid_o (frame_valid)
  );

  assign rise = iDATA_READY & ~rdy_q;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      data_q      <= '0;
      hold_cnt_q  <= '0;
      from_hold_q <= 1'b0;
      err_pend_q  <= 1'b0;
      light_q     <= 8'h00;
      key_q       <= 8'h00;
      kv_q        <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      rdy_q       <= iDATA_READY;
      data_q      <= data_d;
      hold_cnt_q  <= hold_cnt_d;
      from_hold_q <= from_hold_d;
      err_pend_q  <= err_pend_d;
      light_q     <= light_d;
      key_q       <= key_d;
      kv_q        <= kv_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    from_hold_d = from_hold_q;
    err_pend_d  = 1'b0;
    light_d     = light_q;
    key_d       = key_q;
    kv_d        = 1'b0;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    hold_cnt_d  = (hold_cnt_q != '0) ? hold_cnt_q - CW'(1) : '0;

    // A rejection is decided in CHECK but reported one cycle later so that
    // oERR lines up with where oKEY_VALID would have appeared.
    if (err_pend_q) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d     = ST_CHECK;
          data_d      = iDATA;
          from_hold_d = 1'b0;
        end
      end
      ST_CHECK: begin
        if (!frame_valid) begin
          err_pend_d = 1'b1;
          state_d    = from_hold_q ? ST_HOLD : ST_IDLE;
        end else if (from_hold_q && (data_q[23:16] == key_q)) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        light_d    = apply_key(light_q, data_q[23:16]);
        key_d      = data_q[23:16];
        kv_d       = 1'b1;
        hold_cnt_d = HOLD_LOAD;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (rise) begin
          state_d     = ST_CHECK;
          data_d      = iDATA;
          from_hold_d = 1'b1;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign oLIGHT     = light_q;
  assign oKEY       = key_q;
  assign oKEY_VALID = kv_q;
  assign oERR       = err_q;
  assign oERR_CNT   = err_cnt_q;
  assign oSTATE     = state_q;

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Randomized bench for ir_cmd_decoder with a time-based reference model and
// an expected-pulse scoreboard checked by an independent monitor.
module tb_ir_cmd_decoder;

  localparam int HOLDOFF = 1000;
  localparam int W       = 57;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] data = 32'h0;
  logic [7:0]  light, key, err_cnt;
  logic        key_valid, err;
  ir_pkg::state_e state;

  ir_cmd_decoder #(.ADDR(16'h6B86), .HOLDOFF(HOLDOFF)) dut (
    .iCLK        (clk),
    .iRST_n      (rst_n),
    .iDATA_READY (rdy),
    .iDATA       (data),
    .oLIGHT      (light),
    .oKEY        (key),
    .oKEY_VALID  (key_valid),
    .oERR        (err),
    .oERR_CNT    (err_cnt),
    .oSTATE      (state)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // ---------------- reference model ----------------
  logic [7:0] tbl [10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A, 8'h1B};
  logic [7:0] m_light = 8'h00;
  logic [7:0] m_key   = 8'h00;
  int         m_cnt   = 0;
  bit         m_has_acc = 1'b0;
  int         m_acc_cyc = 0;

  // {kind(1=key,0=err), cycle, light, key, err_cnt}
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] pack(input logic kind, input int c, input logic [7:0] l,
                                        input logic [7:0] k, input logic [7:0] n);
    return {kind, c[31:0], l, k, n};
  endfunction

  function automatic bit in_table(input logic [7:0] k);
    for (int i = 0; i < 10; i++) if (tbl[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_light = 8'h00; m_key = 8'h00; m_cnt = 0; m_has_acc = 1'b0;
  endtask

  // e = cycle number of the clock edge that first samples iDATA_READY high
  task automatic model_frame(input logic [31:0] f, input int e);
    logic [7:0] k;
    bit ok;
    k  = f[23:16];
    ok = (f[15:0] == 16'h6B86) && (k == ~f[31:24]) && in_table(k);
    if (!ok) begin
      if (m_cnt < 255) m_cnt++;
      exp_q.push_back(pack(1'b0, e + 2, m_light, m_key, m_cnt[7:0]));
    end else if (m_has_acc && (e <= m_acc_cyc + HOLDOFF) && (k == m_key)) begin
      // same key inside the repeat window: silently dropped
    end else begin
      if (k == 8'h1A) m_light = 8'hFF;
      else if (k == 8'h1B) m_light = 8'h00;
      else m_light[k - 8'd1] = ~m_light[k - 8'd1];
      m_key     = k;
      m_has_acc = 1'b1;
      m_acc_cyc = e + 2;
      exp_q.push_back(pack(1'b1, e + 2, m_light, m_key, m_cnt[7:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] f, input int gap);
    int e;
    @(negedge clk);
    e = cyc + 1;
    // stay clear of the exact end of the repeat window
    while (m_has_acc && (e >= m_acc_cyc + HOLDOFF - 4) && (e <= m_acc_cyc + HOLDOFF + 6)) begin
      @(negedge clk);
      e = cyc + 1;
    end
    data = f;
    rdy  = 1'b1;
    model_frame(f, e);
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [31:0] frame_of(input logic [7:0] k);
    return {~k, k, 16'h6B86};
  endfunction

  function automatic logic [31:0] rand_frame();
    logic [7:0]  k;
    logic [15:0] a;
    logic [7:0]  inv;
    int sel;
    sel = $urandom_range(0, 9);
    k   = tbl[$urandom_range(0, 9)];
    a   = 16'h6B86;
    inv = ~k;
    case (sel)
      0: a   = a ^ (16'h1 << $urandom_range(0, 15));
      1: inv = inv ^ (8'h1 << $urandom_range(0, 7));
      2: begin k = 8'h09 + 8'($urandom_range(0, 16)); inv = ~k; end
      default: ;
    endcase
    return {inv, k, a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    if (key_valid && err) begin
      tests++; fails++;
      $display("FAIL pulse_overlap: oKEY_VALID and oERR both high at cycle %0d", cyc);
    end
    while (exp_q.size() > 0) begin
      exp_v = exp_q[0];
      if (int'(exp_v[55:24]) >= cyc) break;
      void'(exp_q.pop_front());
      tests++; fails++;
      $display("FAIL missing_pulse: pulse absent by deadline, expected kind=%0d at cycle %0d", exp_v[56], exp_v[55:24]);
    end
    if (key_valid || err) begin
      got_v = pack(key_valid, cyc, light, key, err_cnt);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: kv=%0b err=%0b at cycle %0d, expected none", key_valid, err, cyc);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL pulse_check: got kind=%0d cyc=%0d light=%h key=%h cnt=%0d, expected kind=%0d cyc=%0d light=%h key=%h cnt=%0d",
                   got_v[56], got_v[55:24], got_v[23:16], got_v[15:8], got_v[7:0],
                   exp_v[56], exp_v[55:24], exp_v[23:16], exp_v[15:8], exp_v[7:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_light", {24'h0, light}, 32'h0);
    check("reset_key", {24'h0, key}, 32'h0);
    check("reset_kv_err", {30'h0, key_valid, err}, 32'h0);
    check("reset_err_cnt", {24'h0, err_cnt}, 32'h0);
    check("reset_state", {30'h0, state}, {30'h0, ir_pkg::ST_IDLE});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic accept, bad checksum, same-key repeat inside and after the window
    send(32'hFE01_6B86, 10);
    send(32'hFF01_6B86, 80);
    send(32'hFE01_6B86, 5);
    check("light_after_ignored_repeat", {24'h0, light}, 32'h01);
    repeat (HOLDOFF + 10) @(negedge clk);
    send(32'hFE01_6B86, 10);
    check("light_after_window_repeat", {24'h0, light}, 32'h00);

    // all-on then a different key inside the window
    send(frame_of(8'h1A), 10);
    send(frame_of(8'h03), 10);
    check("light_all_on_key3", {24'h0, light}, 32'hFB);

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      send(rand_frame(), ($urandom_range(0, 9) == 0) ? 1100 : $urandom_range(1, 40));
    end

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      send(32'hFF01_6B86 ^ 32'(i << 16 & 32'h0), 1);
    end
    repeat (5) @(negedge clk);
    check("err_cnt_saturated", {24'h0, err_cnt}, 32'd255);

    // reset while a frame is in CHECK, with iDATA_READY still high at release
    repeat (5) @(negedge clk);
    data = 32'hFD02_6B86;
    rdy  = 1'b1;
    @(posedge clk);
    #1;
    check("state_before_reset", {30'h0, state}, {30'h0, ir_pkg::ST_CHECK});
    rst_n = 1'b0;
    #1;
    check("midrst_light", {24'h0, light}, 32'h0);
    check("midrst_key", {24'h0, key}, 32'h0);
    check("midrst_err_cnt", {24'h0, err_cnt}, 32'h0);
    check("midrst_kv_err", {30'h0, key_valid, err}, 32'h0);
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    model_frame(32'hFD02_6B86, cyc + 1);
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    repeat (10) @(negedge clk);
    check("light_after_reset_edge", {24'h0, light}, 32'h02);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
